// File: rtl/arduino_cmd_pkg.sv
// arduino_cmd_pkg: shared opcodes, widths, command record and FSM state types.
package arduino_cmd_pkg;
  localparam int ADDR_W = 11;
  localparam int COLOR_W = 6;
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;
  typedef struct packed {
    logic [1:0] op;
    logic [ADDR_W-1:0] addr;
    logic [COLOR_W-1:0] color;
  } cmd_t;
  typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2} pstate_t;
  typedef enum logic [1:0] {D_IDLE, D_WRITE, D_FILL} dstate_t;
endpackage

// File: rtl/arduino_cmd_rx_fifo.sv
// cmd_fifo: synchronous FIFO of command records; pointers carry an extra wrap bit.
module cmd_fifo import arduino_cmd_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  cmd_t mem_q [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic do_push, do_pop;
  assign empty = wp_q == rp_q;
  assign full = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
  assign dout = mem_q[rp_q[AW-1:0]];
  always_comb begin
    do_push = push & ~full;
    do_pop = pop & ~empty;
    wp_d = do_push ? wp_q + 1'b1 : wp_q;
    rp_d = do_pop ? rp_q + 1'b1 : rp_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/arduino_cmd_rx.sv
// arduino_cmd_rx: parses 3-byte strobed Arduino packets, queues them and drains them
// as single writes or full-memory fills over a valid/ready port.
module arduino_cmd_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = 11,
  parameter int COLOR_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic [7:0] bus_data,
  input  logic bus_strobe,
  input  logic bus_sync,
  output logic wr_valid,
  input  logic wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [COLOR_W-1:0] wr_color,
  output logic busy,
  output logic overflow
);
  import arduino_cmd_pkg::*;
  logic [2:0] stb_q;
  logic [1:0] rsy_q;
  pstate_t pst_q, pst_d;
  dstate_t dst_q, dst_d;
  logic [7:0] b0_q, b0_d, b1_q, b1_d;
  logic ovf_q, ovf_d, valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic resync, stb_edge, live, push, pop, full, empty, hs;
  cmd_t din, dout;
  assign resync = rsy_q[1];
  assign stb_edge = stb_q[1] & ~stb_q[2] & ~resync;
  assign din = {b0_q[7:6], b0_q[2:0], b1_q, bus_data[5:0]};
  assign live = din.op == OP_WRITE || din.op == OP_FILL;
  assign hs = valid_q & wr_ready;
  assign pop = dst_q == D_IDLE && !empty;
  assign wr_valid = valid_q;
  assign wr_addr = addr_q;
  assign wr_color = color_q;
  assign overflow = ovf_q;
  assign busy = !empty || dst_q != D_IDLE;
  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop),
    .dout(dout), .full(full), .empty(empty)
  );
  always_comb begin
    pst_d = pst_q;
    b0_d = b0_q;
    b1_d = b1_q;
    ovf_d = ovf_q;
    push = 1'b0;
    if (resync) pst_d = BYTE0;
    else if (stb_edge) begin
      case (pst_q)
        BYTE0: begin b0_d = bus_data; pst_d = BYTE1; end
        BYTE1: begin b1_d = bus_data; pst_d = BYTE2; end
        default: begin
          push = live & ~full;
          ovf_d = ovf_q | (live & full);
          pst_d = BYTE0;
        end
      endcase
    end
  end
  always_comb begin
    dst_d = dst_q;
    valid_d = valid_q;
    addr_d = addr_q;
    color_d = color_q;
    case (dst_q)
      D_IDLE: if (!empty) begin
        dst_d = dout.op == OP_FILL ? D_FILL : D_WRITE;
        valid_d = 1'b1;
        addr_d = dout.op == OP_FILL ? '0 : dout.addr;
        color_d = dout.color;
      end
      D_WRITE: if (hs) begin
        dst_d = D_IDLE;
        valid_d = 1'b0;
      end
      default: if (hs) begin
        dst_d = &addr_q ? D_IDLE : D_FILL;
        valid_d = ~&addr_q;
        addr_d = &addr_q ? addr_q : addr_q + 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_q <= '0;
      rsy_q <= '0;
      pst_q <= BYTE0;
      dst_q <= D_IDLE;
      b0_q <= '0;
      b1_q <= '0;
      ovf_q <= 1'b0;
      valid_q <= 1'b0;
      addr_q <= '0;
      color_q <= '0;
    end else begin
      stb_q <= {stb_q[1:0], bus_strobe};
      rsy_q <= {rsy_q[0], bus_sync};
      pst_q <= pst_d;
      dst_q <= dst_d;
      b0_q <= b0_d;
      b1_q <= b1_d;
      ovf_q <= ovf_d;
      valid_q <= valid_d;
      addr_q <= addr_d;
      color_q <= color_d;
    end
  end
endmodule

// File: tb/tb_arduino_cmd_rx.sv
// tb_arduino_cmd_rx: directed packet sequences with hand-computed write logs.
module tb_arduino_cmd_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] bus_data = '0;
  logic bus_strobe = 1'b0;
  logic bus_sync = 1'b0;
  logic wr_ready = 1'b0;
  logic wr_valid, busy, overflow;
  logic [10:0] wr_addr;
  logic [5:0] wr_color;
  logic [16:0] log_q[$];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  arduino_cmd_rx dut (
    .clk(clk), .rst(rst), .bus_data(bus_data), .bus_strobe(bus_strobe),
    .bus_sync(bus_sync), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_color(wr_color), .busy(busy), .overflow(overflow)
  );
  always @(posedge clk) if (!rst && wr_valid && wr_ready) log_q.push_back({wr_addr, wr_color});
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus_data = b;
    bus_strobe = 1'b1;
    repeat (6) @(negedge clk);
    bus_strobe = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a);
    send_byte(b);
    send_byte(c);
  endtask
  task automatic wait_idle(input int max, output bit ok);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    ok = !busy;
  endtask
  initial begin
    bit ok, stable;
    int bad, n;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(wr_valid), 0);
    check("rst_addr", 32'(wr_addr), 0);
    check("rst_color", 32'(wr_color), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    wr_ready = 1'b1;
    send_pkt(8'h43, 8'h21, 8'h2A);
    wait_idle(50, ok);
    check("single_idle", 32'(ok), 1);
    check("single_count", log_q.size(), 1);
    if (log_q.size() > 0) check("single_entry", 32'(log_q[0]), {15'd0, 11'h321, 6'h2A});
    check("single_busy", 32'(busy), 0);
    log_q.delete();
    wr_ready = 1'b0;
    send_pkt(8'h43, 8'h21, 8'h2A);
    n = 0;
    while (!wr_valid && n < 20) begin @(negedge clk); n++; end
    check("bp_valid", 32'(wr_valid), 1);
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(wr_valid && wr_addr == 11'h321 && wr_color == 6'h2A)) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 1);
    check("bp_no_write", log_q.size(), 0);
    wr_ready = 1'b1;
    @(negedge clk);
    check("bp_done_valid", 32'(wr_valid), 0);
    check("bp_count", log_q.size(), 1);
    if (log_q.size() > 0) check("bp_entry", 32'(log_q[0]), {15'd0, 11'h321, 6'h2A});
    log_q.delete();
    send_pkt(8'h80, 8'h00, 8'h30);
    wait_idle(2300, ok);
    check("fill_idle", 32'(ok), 1);
    check("fill_count", log_q.size(), 2048);
    bad = 0;
    for (int i = 0; i < log_q.size(); i++)
      if (log_q[i] !== {i[10:0], 6'h30}) bad++;
    check("fill_order", bad, 0);
    check("fill_valid", 32'(wr_valid), 0);
    log_q.delete();
    wr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_pkt(8'h40, 8'(8'h10 + i), 8'(i + 1));
      if (i == 4) check("ovf_not_yet", 32'(overflow), 0);
    end
    repeat (3) @(negedge clk);
    check("ovf_set", 32'(overflow), 1);
    check("ovf_head_valid", 32'(wr_valid), 1);
    check("ovf_head_addr", 32'(wr_addr), 32'h10);
    check("ovf_head_color", 32'(wr_color), 1);
    check("ovf_busy", 32'(busy), 1);
    wr_ready = 1'b1;
    wait_idle(50, ok);
    check("ovf_idle", 32'(ok), 1);
    check("ovf_count", log_q.size(), 5);
    bad = 0;
    for (int i = 0; i < log_q.size(); i++)
      if (log_q[i] !== {11'(16 + i), 6'(i + 1)}) bad++;
    check("ovf_order", bad, 0);
    check("ovf_sticky", 32'(overflow), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("ovf_cleared", 32'(overflow), 0);
    log_q.delete();
    send_byte(8'h41);
    bus_sync = 1'b1;
    repeat (4) @(negedge clk);
    bus_sync = 1'b0;
    repeat (4) @(negedge clk);
    send_pkt(8'h00, 8'h00, 8'h00);
    send_pkt(8'h40, 8'h05, 8'h01);
    wait_idle(50, ok);
    check("sync_idle", 32'(ok), 1);
    check("sync_count", log_q.size(), 1);
    if (log_q.size() > 0) check("sync_entry", 32'(log_q[0]), {15'd0, 11'h005, 6'h01});
    log_q.delete();
    send_pkt(8'h80, 8'h00, 8'h15);
    n = 0;
    while (log_q.size() < 100 && n < 300) begin @(negedge clk); n++; end
    check("mid_reached", log_q.size(), 100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_valid", 32'(wr_valid), 0);
    check("mid_busy", 32'(busy), 0);
    repeat (50) @(negedge clk);
    check("mid_no_more", log_q.size(), 100);
    check("mid_valid_late", 32'(wr_valid), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
